// File: rtl/image_rom_arbiter_pkg.sv
// rtl/image_rom_arbiter_pkg.sv - types and constants for the image ROM arbiter
`include "display_defs.vh"

package image_rom_arbiter_pkg;

    localparam int X_W   = `COORD_X_W;
    localparam int Y_W   = `COORD_Y_W;
    localparam int PIX_W = `PIX_W;
    localparam int IMG_W = `IMG_W;
    localparam int IMG_H = `IMG_H;
    localparam int ID_W  = 3;

    localparam logic [PIX_W-1:0] TRANSPARENT_PIX = `TRANSPARENT;

    // One in-flight read: who asked for it and whether the ROM is bypassed
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic            oob;
    } tag_t;

    function automatic logic is_oob(input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                                    input int w, input int h);
        return (int'(x) >= w) || (int'(y) >= h);
    endfunction

    function automatic logic is_transparent(input logic [PIX_W-1:0] p);
        return p[`ALPHA_MSB:`ALPHA_LSB] == '0;
    endfunction

endpackage

// File: rtl/image_rom_arbiter_if.sv
// rtl/image_rom_arbiter_if.sv - requester, reader and return bus of the image ROM arbiter
interface image_rom_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import image_rom_arbiter_pkg::*;

    logic                     hold;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*X_W-1:0]   req_x;
    logic [NUM_REQ*Y_W-1:0]   req_y;
    logic [NUM_REQ-1:0]       gnt;
    logic [X_W-1:0]           img_x;
    logic [Y_W-1:0]           img_y;
    logic [PIX_W-1:0]         img_pixel;
    logic [NUM_REQ-1:0]       rd_valid;
    logic [PIX_W-1:0]         rd_pixel;
    logic                     rd_transparent;

    // Requesters plus image reader
    modport master (
        output hold, req, req_x, req_y, img_pixel,
        input  gnt, img_x, img_y, rd_valid, rd_pixel, rd_transparent
    );

    // Arbiter
    modport slave (
        input  hold, req, req_x, req_y, img_pixel,
        output gnt, img_x, img_y, rd_valid, rd_pixel, rd_transparent
    );

endinterface

// File: rtl/display_defs.vh
// rtl/display_defs.vh - shared display pipeline constants
`ifndef DISPLAY_DEFS_VH
`define DISPLAY_DEFS_VH

`define IMG_W        300
`define IMG_H        300
`define COORD_X_W    10
`define COORD_Y_W    9
`define PIX_W        16
`define ALPHA_MSB    3
`define ALPHA_LSB    0
`define TRANSPARENT  16'h0000

`endif

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin search starting at a pointer
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    // Walk requesters ptr, ptr+1, ... (mod N); the first asserted one wins
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!any_o && req_i[i] && (((int'(ptr_i) + k) % N) == i)) begin
                    any_o    = 1'b1;
                    idx_o    = IW'(i);
                    gnt_o[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/image_rom_arbiter.sv
// rtl/image_rom_arbiter.sv - shares one image ROM reader among several requesters
module image_rom_arbiter
    import image_rom_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = IMG_W,
    parameter int HEIGHT  = IMG_H,
    parameter int LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst,
    image_rom_arbiter_if.slave  bus
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IW-1:0]      ptr_q, ptr_d;
    logic [NUM_REQ-1:0] req_eff;
    logic [NUM_REQ-1:0] gnt_c;
    logic [IW-1:0]      gnt_idx;
    logic               gnt_any;
    logic [X_W-1:0]     sel_x;
    logic [Y_W-1:0]     sel_y;
    logic               sel_oob;
    logic [X_W-1:0]     img_x_q;
    logic [Y_W-1:0]     img_y_q;
    tag_t               tag_q [LATENCY+1];
    tag_t               tag_last;

    // Requests are masked during reset and hold so nothing is granted then
    assign req_eff = (rst || bus.hold) ? '0 : bus.req;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req_i (req_eff),
        .ptr_i (ptr_q),
        .gnt_o (gnt_c),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    assign bus.gnt = gnt_c;

    // Coordinate mux driven by the one-hot grant
    always_comb begin
        sel_x = '0;
        sel_y = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_c[i]) begin
                sel_x = bus.req_x[i*X_W +: X_W];
                sel_y = bus.req_y[i*Y_W +: Y_W];
            end
        end
        sel_oob = is_oob(sel_x, sel_y, WIDTH, HEIGHT);
    end

    // Next search starts just past the last winner
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Reader address; out-of-image requests never touch the ROM
    always_ff @(posedge clk) begin
        if (rst) begin
            img_x_q <= '0;
            img_y_q <= '0;
        end else if (gnt_any && !sel_oob) begin
            img_x_q <= sel_x;
            img_y_q <= sel_y;
        end
    end

    assign bus.img_x = img_x_q;
    assign bus.img_y = img_y_q;

    // Tag pipeline tracks each read until the ROM word comes back
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0].valid <= gnt_any;
            tag_q[0].id    <= ID_W'(gnt_idx);
            tag_q[0].oob   <= gnt_any && sel_oob;
            for (int i = 1; i <= LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign tag_last = tag_q[LATENCY];

    // Steer the returning word to its requester, substituting transparent for oob
    always_comb begin
        bus.rd_valid = '0;
        bus.rd_pixel = TRANSPARENT_PIX;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.rd_valid[i] = tag_last.valid && (int'(tag_last.id) == i);
        end
        if (tag_last.valid && !tag_last.oob) begin
            bus.rd_pixel = bus.img_pixel;
        end
        bus.rd_transparent = tag_last.valid && is_transparent(bus.rd_pixel);
    end

endmodule

// File: tb/tb_image_rom_arbiter.sv
// tb/tb_image_rom_arbiter.sv - scoreboard bench for image_rom_arbiter
module tb_image_rom_arbiter;

    localparam int N   = 4;
    localparam int W   = 300;
    localparam int H   = 300;
    localparam int LAT = 2;

    typedef struct {
        logic [N-1:0] oh;
        logic [15:0]  pix;
        int           due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    image_rom_arbiter_if #(.NUM_REQ(N)) bus ();

    image_rom_arbiter #(.NUM_REQ(N), .WIDTH(W), .HEIGHT(H), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Requester state as seen by the bench
    logic         pend [N];
    int           px [N];
    int           py [N];
    logic [N-1:0] granted = '0;
    logic         hold_v = 1'b0;

    // Reference model state
    int           m_ptr = 0;
    int           exp_img_x = 0;
    int           exp_img_y = 0;
    exp_t         q [$];

    function automatic logic [15:0] word(input int a);
        logic [31:0] t;
        t = 32'(a) * 32'd40503 + 32'd12345;
        return t[15:0] ^ t[31:16];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Image reader: word at y*W+x, LATENCY cycles after the address
    logic [15:0] p1 = '0;
    logic [15:0] pix_r = '0;
    always @(posedge clk) begin
        p1    <= word(int'(bus.img_y) * W + int'(bus.img_x));
        pix_r <= p1;
    end
    assign bus.img_pixel = pix_r;

    // Expected grant and issue; pushes expected returns
    always @(negedge clk) begin
        logic [N-1:0] eg;
        int gi;
        eg = '0;
        gi = -1;
        chk("img_x", 32'(bus.img_x), 32'(exp_img_x));
        chk("img_y", 32'(bus.img_y), 32'(exp_img_y));
        if (!rst && !hold_v) begin
            for (int k = 0; k < N; k++) begin
                if (gi < 0 && pend[(m_ptr + k) % N]) gi = (m_ptr + k) % N;
            end
        end
        if (gi >= 0) eg[gi] = 1'b1;
        chk("gnt", 32'(bus.gnt), 32'(eg));
        if (gi >= 0) begin
            exp_t e;
            logic oob;
            oob   = (px[gi] >= W) || (py[gi] >= H);
            e.oh  = eg;
            e.pix = oob ? 16'h0000 : word(py[gi] * W + px[gi]);
            e.due = cyc + 1 + LAT;
            q.push_back(e);
            m_ptr = (gi + 1) % N;
            if (!oob) begin
                exp_img_x = px[gi];
                exp_img_y = py[gi];
            end
        end
        granted = eg;
        if (rst) begin
            m_ptr = 0;
            exp_img_x = 0;
            exp_img_y = 0;
            while (q.size() > 0 && q[q.size()-1].due > cyc) void'(q.pop_back());
        end
    end

    // Return monitor
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due == cyc) begin
            exp_t e;
            e = q.pop_front();
            chk("rd_valid", 32'(bus.rd_valid), 32'(e.oh));
            chk("rd_pixel", 32'(bus.rd_pixel), 32'(e.pix));
            chk("rd_transparent", 32'(bus.rd_transparent), 32'(e.pix[3:0] == 4'h0));
        end else begin
            chk("rd_valid_idle", 32'(bus.rd_valid), 32'd0);
            chk("rd_pixel_idle", 32'(bus.rd_pixel), 32'd0);
            chk("rd_transparent_idle", 32'(bus.rd_transparent), 32'd0);
        end
    end

    task automatic set_req(input int i, input int x, input int y);
        pend[i] = 1'b1;
        px[i]   = x;
        py[i]   = y;
    endtask

    // Drive one cycle of stimulus, then retire the requests that were granted
    task automatic cycle();
        logic [N-1:0]    r;
        logic [N*10-1:0] rx;
        logic [N*9-1:0]  ry;
        for (int i = 0; i < N; i++) begin
            r[i]           = pend[i];
            rx[i*10 +: 10] = 10'(px[i]);
            ry[i*9 +: 9]   = 9'(py[i]);
        end
        bus.req   = r;
        bus.req_x = rx;
        bus.req_y = ry;
        bus.hold  = hold_v;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (granted[i]) pend[i] = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    function automatic int rnd_coord(input int lim);
        int r;
        r = int'($urandom_range(0, 7));
        if (r == 0) return int'($urandom_range(0, lim - 1));
        if (r == 1) return 296 + int'($urandom_range(0, 7));
        return int'($urandom_range(0, 299));
    endfunction

    initial begin
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            px[i]   = 0;
            py[i]   = 0;
        end
        do_reset();

        // Single request
        set_req(0, 10, 20);
        idle(5);

        // Fairness from reset
        do_reset();
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++) if (!pend[i]) set_req(i, 5 * k + i, 3 * k + i);
            cycle();
        end
        idle(4);

        // Out of range and corners
        set_req(2, 300, 5);
        idle(2);
        set_req(1, 299, 299);
        set_req(3, 1023, 511);
        idle(2);
        set_req(0, 0, 300);
        set_req(1, 299, 0);
        idle(5);

        // Hold mid-stream with two requesters
        do_reset();
        for (int k = 0; k < 12; k++) begin
            hold_v = (k >= 5 && k <= 7);
            for (int i = 0; i < 2; i++) if (!pend[i]) set_req(i, 7 * k + i, 2 * k + i);
            cycle();
        end
        hold_v = 1'b0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        idle(4);

        // Reset with reads in flight
        for (int i = 0; i < N; i++) set_req(i, 100 + i, 50 + i);
        idle(2);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        idle(5);

        // Randomised traffic
        for (int k = 0; k < 2000; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) set_req(i, rnd_coord(1024), rnd_coord(512));
            end
            hold_v = ($urandom_range(0, 7) == 0);
            rst    = ($urandom_range(0, 149) == 0);
            cycle();
        end
        hold_v = 1'b0;
        rst    = 1'b0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        idle(8);

        chk("drain", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/image_rom_arbiter.md
# image_rom_arbiter

Shares one 300×300 RGBA image ROM reader among several display requesters (mole sprites, overlay layers) in the display pipeline. Each cycle it grants at most one pending coordinate request (round-robin), drives the reader's x/y inputs, and tracks in-flight reads through a tag pipeline. Each returned pixel goes back to the requester that issued it. Out-of-image coordinates are answered locally with a transparent pixel, so every granted request returns exactly one pixel at fixed latency.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 300, image width in pixels
- HEIGHT, 300, image height in pixels
- LATENCY, 2, reader latency: cycles from img_x/img_y valid to img_pixel valid
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- hold  in  1  when high, no new grants; in-flight reads still complete
- req  in  NUM_REQ  per-requester request; held with coordinates until granted
- req_x  in  NUM_REQ*10  packed x coordinates, requester i at [10i+9:10i]
- req_y  in  NUM_REQ*9  packed y coordinates, requester i at [9i+8:9i]
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as accepted req
- img_x  out  10  registered x to image reader
- img_y  out  9  registered y to image reader
- img_pixel  in  16  reader output, R[15:12] G[11:8] B[7:4] A[3:0]
- rd_valid  out  NUM_REQ  one-hot: returned pixel belongs to requester i
- rd_pixel  out  16  returned pixel, valid when any rd_valid bit is set
- rd_transparent  out  1  rd_valid != 0 and rd_pixel[3:0] == 0

## Operation
- Arbitration: round-robin over requesters with req[i] = 1. The search starts at pointer `ptr`. Grant the first asserted requester found at or after ptr, wrapping modulo NUM_REQ.
- gnt is all-zero when rst = 1, when hold = 1, or when req = 0.
- Pointer update: after a grant to requester i, ptr <= (i+1) mod NUM_REQ. With no grant, ptr is unchanged.
- Transfer rule: a transfer occurs when gnt[i] = 1. The requester may change its coordinates or deassert req in the next cycle.
- Issue on a grant:
  - img_x/img_y <= the granted coordinates.
  - Tag stage 0 <= {valid = 1, id = i, oob}, where oob = (x >= WIDTH) or (y >= HEIGHT).
  - For an oob request, img_x/img_y hold their previous value.
- Idle: img_x/img_y hold their last value and the stage-0 tag is loaded with valid = 0.
- Tag pipeline: LATENCY+1 stages, shifting every cycle with no stall. At the final stage with valid = 1:
  - rd_valid = one-hot(id).
  - rd_pixel = oob ? 16'h0000 : img_pixel.
- Non-final cycles: rd_valid = 0 and rd_pixel = 16'h0000.
- Back-to-back: a new grant is possible every cycle. Throughput is 1 pixel/cycle. Returns come back in grant order.
- Boundaries:
  - x = 299 and y = 299 are in range. x = 300 or y = 300 is oob. Max field values (1023, 511) are oob.
  - Single requester held high: granted every cycle.
  - hold asserted mid-stream: grants stop the same cycle; the already-issued reads return normally.

## Timing
- Grant in cycle T, then:
  - img_x/img_y valid in T+1.
  - rd_valid/rd_pixel valid in T+1+LATENCY, i.e. T+3 at default.
- Reset values: ptr = 0, img_x = 0, img_y = 0, all tag valids = 0, rd_valid = 0, rd_pixel = 0, rd_transparent = 0.
- Reset mid-operation: all in-flight tags are cleared. No rd_valid is produced for reads issued before reset. The first possible grant is in the cycle after rst deasserts.
- No combinational path from img_pixel to gnt. The only combinational path to gnt is from req, hold, rst and ptr.

## Structure
- Shared header display_defs.vh:
  - IMG_W/IMG_H defaults, coordinate widths (10/9), pixel width 16.
  - Alpha field position [3:0] and the TRANSPARENT pixel constant 16'h0000.
- One sub-module, rr_arbiter (parameter N): req vector, ptr in → one-hot gnt, granted index.
- The ptr register lives in the top module.
- Top module: coordinate mux, oob compare, issue registers, tag shift register.

## Test plan
- Single request: req = 4'b0001 with x = 10, y = 20 in cycle 0 → gnt = 0001 in cycle 0; img_x = 10, img_y = 20 in cycle 1; rd_valid = 0001 in cycle 3 with rd_pixel = the reader model's word at address 20*300+10.
- Fairness: req = 4'b1111 held for 8 cycles from reset → grants 0,1,2,3,0,1,2,3. rd_valid follows the same order 3 cycles later, one pixel per cycle.
- Out of range: requester 2 with x = 300, y = 5 → rd_valid = 0100 at T+3 with rd_pixel = 0 and rd_transparent = 1; img_x/img_y unchanged.
- Corner: x = 299, y = 299 → rd_pixel = word 89999. A word with A = 0 gives rd_transparent = 1; A = 4'hF gives 0.
- Hold: req = 4'b0011 streaming; assert hold at cycle 5 for 3 cycles → no gnt in cycles 5-7; the grants from cycles 3-4 still return in cycles 6-7; the round-robin order resumes at cycle 8 without skipping a requester.
- Reset mid-flight: grants in cycles 0-1, rst = 1 in cycle 2 → no rd_valid in any later cycle for those grants; all outputs 0 the cycle after rst is sampled; ptr = 0.
